// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller: load-use hazards and multi-cycle divide sequencing
// Optional stall-cycle performance counter enabled by PIPE_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_re1,
  input  logic [4:0]  id_raddr1,
  input  logic        id_re2,
  input  logic [4:0]  id_raddr2,
  input  logic        ex_is_load,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_div_start,
  input  logic        except_flush,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        div_ready,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] STALL_LU  = 6'b000111;
  localparam logic [5:0] STALL_DIV = 6'b001111;
  localparam logic [5:0] CNT_INIT  = 6'(DIV_CYCLES - 1);

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       load_use;

  assign load_use = ex_is_load & ex_wreg & (ex_waddr != 5'd0) &
                    ((id_re1 & (id_raddr1 == ex_waddr)) |
                     (id_re2 & (id_raddr2 == ex_waddr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 6'b0;
    flush     = 1'b0;
    div_ready = 1'b0;
    if (except_flush) begin
      flush     = 1'b1;
      state_nxt = IDLE;
      cnt_nxt   = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_div_start) begin
            stall     = STALL_DIV;
            cnt_nxt   = CNT_INIT;
            state_nxt = (CNT_INIT == 6'd1) ? DONE : BUSY;
          end else if (load_use) begin
            stall = STALL_LU;
          end
        end
        BUSY: begin
          // DONE is entered as the count reaches 1, so the result cycle is T+DIV_CYCLES-1
          stall   = STALL_DIV;
          cnt_nxt = cnt - 6'd1;
          if (cnt == 6'd2) state_nxt = DONE;
        end
        DONE: begin
          div_ready = 1'b1;
          if (load_use) stall = STALL_LU;
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end
      endcase
    end
    if (rst) begin
      stall     = 6'b0;
      flush     = 1'b0;
      div_ready = 1'b0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               perf_cnt <= 32'd0;
    else if (stall != 6'b0) perf_cnt <= perf_cnt + 32'd1;
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
// Table-driven hazard vectors plus hand-written divide, flush and reset sequences.
module tb_pipe_ctrl;

  localparam int DIV = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_re1, id_re2, ex_is_load, ex_wreg, ex_div_start, except_flush;
  logic [4:0]  id_raddr1, id_raddr2, ex_waddr;
  logic [5:0]  stall;
  logic        flush, div_ready;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  pipe_ctrl #(.DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst(rst),
    .id_re1(id_re1), .id_raddr1(id_raddr1),
    .id_re2(id_re2), .id_raddr2(id_raddr2),
    .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
    .ex_div_start(ex_div_start), .except_flush(except_flush),
    .stall(stall), .flush(flush), .div_ready(div_ready),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       re1;
    logic [4:0] a1;
    logic       re2;
    logic [4:0] a2;
    logic       ld;
    logic       wr;
    logic [4:0] wa;
    logic       exc;
    logic [5:0] st;
    logic       fl;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
    ex_is_load = 0; ex_wreg = 0; ex_waddr = 0;
    ex_div_start = 0; except_flush = 0;
  endtask

  task automatic set_hit(input logic [4:0] r);
    id_re1 = 1; id_raddr1 = r; ex_is_load = 1; ex_wreg = 1; ex_waddr = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // abort_at < DIV aborts with except_flush at that cycle offset; lu_done adds a load-use hit at DONE
  task automatic run_div(input int abort_at, input bit lu_done);
    ex_div_start = 1;
    for (int k = 0; k < DIV; k++) begin
      if (k == abort_at) begin
        except_flush = 1;
        #2;
        chk("abort_flush", 32'(flush), 32'd1);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_ready", 32'(div_ready), 32'd0);
        tick();
        clear_inputs();
        #2;
        chk("abort_idle_stall", 32'(stall), 32'd0);
        chk("abort_idle_flush", 32'(flush), 32'd0);
        return;
      end
      if (k == DIV - 1) begin
        if (lu_done) set_hit(5'd4);
        #2;
        chk("div_done_ready", 32'(div_ready), 32'd1);
        chk("div_done_stall", 32'(stall), lu_done ? 32'h07 : 32'h00);
        if (lu_done) exp_cnt++;
      end else begin
        #2;
        chk("div_busy_stall", 32'(stall), 32'h0f);
        chk("div_busy_ready", 32'(div_ready), 32'd0);
        exp_cnt++;
      end
      tick();
    end
    clear_inputs();
    #2;
    chk("div_after_stall", 32'(stall), 32'd0);
    chk("div_after_ready", 32'(div_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 5'd5,  0, 5'd0,  1, 1, 5'd5,  0, 6'b000111, 0};
    vecs[1] = '{1, 5'd0,  0, 5'd0,  1, 1, 5'd0,  0, 6'b000000, 0};
    vecs[2] = '{0, 5'd0,  1, 5'd7,  1, 1, 5'd7,  0, 6'b000111, 0};
    vecs[3] = '{1, 5'd7,  1, 5'd3,  1, 1, 5'd9,  0, 6'b000000, 0};
    vecs[4] = '{0, 5'd5,  0, 5'd5,  1, 1, 5'd5,  0, 6'b000000, 0};
    vecs[5] = '{1, 5'd5,  0, 5'd0,  0, 1, 5'd5,  0, 6'b000000, 0};
    vecs[6] = '{1, 5'd5,  0, 5'd0,  1, 0, 5'd5,  0, 6'b000000, 0};
    vecs[7] = '{1, 5'd5,  0, 5'd0,  1, 1, 5'd5,  1, 6'b000000, 1};
    vecs[8] = '{0, 5'd0,  0, 5'd0,  0, 0, 5'd0,  1, 6'b000000, 1};
    vecs[9] = '{1, 5'd31, 1, 5'd2,  1, 1, 5'd31, 0, 6'b000111, 0};

    clear_inputs();
    rst = 1;
    except_flush = 1;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_ready", 32'(div_ready), 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);
    tick();
    tick();
    rst = 0;
    except_flush = 0;

    for (int i = 0; i < 10; i++) begin
      id_re1 = vecs[i].re1; id_raddr1 = vecs[i].a1;
      id_re2 = vecs[i].re2; id_raddr2 = vecs[i].a2;
      ex_is_load = vecs[i].ld; ex_wreg = vecs[i].wr; ex_waddr = vecs[i].wa;
      except_flush = vecs[i].exc;
      #2;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].st));
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_ready", i), 32'(div_ready), 32'd0);
      if (vecs[i].st != 6'b0) exp_cnt++;
      tick();
      clear_inputs();
    end

    run_div(10, 0);
    tick();
    run_div(DIV, 1);
    tick();
    run_div(DIV, 0);
    tick();

    set_hit(5'd6);
    ex_div_start = 1;
    except_flush = 1;
    #2;
    chk("both_exc_stall", 32'(stall), 32'd0);
    chk("both_exc_flush", 32'(flush), 32'd1);
    except_flush = 0;
    #1;
    chk("both_stall", 32'(stall), 32'h0f);
    chk("both_flush", 32'(flush), 32'd0);
    except_flush = 1;
    tick();
    clear_inputs();
    #2;
    chk("both_after_stall", 32'(stall), 32'd0);
    chk("both_after_ready", 32'(div_ready), 32'd0);

`ifdef PIPE_PERF_CNT_EN
    chk("perf_count", stall_cycles, 32'(exp_cnt));
`else
    chk("perf_count", stall_cycles, 32'd0);
`endif

    ex_div_start = 1;
    for (int k = 0; k < 5; k++) tick();
    #2;
    chk("pre_rst_busy", 32'(stall), 32'h0f);
    rst = 1;
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_ready", 32'(div_ready), 32'd0);
    chk("async_rst_flush", 32'(flush), 32'd0);
    chk("async_rst_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    rst = 0;
    ex_div_start = 0;
    #1;
    chk("post_rst_idle", 32'(stall), 32'd0);
    tick();
    #2;
    chk("post_rst_idle2", 32'(stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage CPU. Detects load-use hazards that the register file's EX/MEM/WB bypass cannot cover, and sequences the multi-cycle divider held in EX. Drives a per-stage stall vector and a flush strobe into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Sits beside the register file; consumes the same ID read addresses and EX write-back info.

## Interface
- DIV_CYCLES, 33, total cycles a divide occupies EX, counting the start cycle; legal range 2..63.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_re1  in  1  ID reads port 1
- id_raddr1  in  5  ID read address 1
- id_re2  in  1  ID reads port 2
- id_raddr2  in  5  ID read address 2
- ex_is_load  in  1  instruction in EX is a load
- ex_wreg  in  1  EX instruction writes a register
- ex_waddr  in  5  EX destination register
- ex_div_start  in  1  level; high while a divide sits in EX
- except_flush  in  1  exception/eret taken in MEM
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
- flush  out  1  clear all pipeline registers this cycle
- div_ready  out  1  divider result valid; EX may advance
- stall_cycles  out  32  count of cycles with stall != 0

## Operation
- FSM states: IDLE, BUSY, DONE. Reset: IDLE; cnt = 0; stall_cycles = 0.
- Load-use hit (combinational): ex_is_load & ex_wreg & ex_waddr != 0 & ((id_re1 & id_raddr1 == ex_waddr) | (id_re2 & id_raddr2 == ex_waddr)).
- Load-use only: stall = 6'b000111 (PC/IF/ID held, bubble into EX).
- IDLE & ex_div_start: stall = 6'b001111 (EX held, bubble into MEM); next BUSY, cnt <= DIV_CYCLES-1.
- BUSY: stall = 6'b001111; cnt decrements; when cnt == 1 next DONE.
- DONE: stall = 0 unless load-use hit; div_ready = 1; next IDLE. ex_div_start ignored in BUSY and DONE (same instruction).
- Priority: except_flush > divide stall > load-use stall. Divide stall is a superset of load-use stall.
- except_flush: flush = 1, stall = 0, div_ready = 0; next state IDLE, cnt <= 0 (aborts divide in progress).
- Address 0 never hazards. Outputs otherwise 0.
- cnt width 6 bits; no wrap, DIV_CYCLES bounded.

## Timing
- stall, flush, div_ready are combinational from current state and inputs; no added latency.
- Divide started in cycle T: stall asserted T .. T+DIV_CYCLES-2; div_ready in T+DIV_CYCLES-1; divide leaves EX at edge ending T+DIV_CYCLES-1.
- Load-use: single stall cycle; next cycle the load is in MEM and the bypass covers it.
- All outputs 0 while rst high; rst mid-divide returns to IDLE immediately.
- ex_div_start in the cycle after DONE (new divide) starts a fresh sequence.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_cycles increments by 1 (wraps at 2^32) on every clock edge where stall != 0; cleared by rst only.
- Not defined: no counter register; stall_cycles tied to 32'b0. All other behaviour identical.

## Test plan
- Load-use: ex_is_load=1, ex_wreg=1, ex_waddr=5, id_re1=1, id_raddr1=5 -> stall=6'b000111 for 1 cycle; with ex_waddr=0 -> stall=0.
- Divide, DIV_CYCLES=33: ex_div_start held high from T -> stall=6'b001111 for 32 cycles, div_ready=1 at T+32 only, state IDLE at T+33.
- Flush mid-divide: except_flush=1 at T+10 -> flush=1, stall=0 that cycle, state IDLE; later div_start restarts full 33-cycle sequence.
- Simultaneous load-use and divide start -> stall=6'b001111; except_flush with both -> stall=0, flush=1.
- Async reset asserted in BUSY between edges -> outputs 0 immediately, state IDLE, stall_cycles=0.
- With PIPE_PERF_CNT_EN: one load-use plus one 33-cycle divide -> stall_cycles=33; without macro -> stall_cycles=0.
